// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encoding, FSM state type and iterative-unit
//                operation type for the multi-cycle execute-stage ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // 5-bit ALU opcodes (values are unique and fixed by the decode stage)
  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SLL   = 5'd3;
  localparam logic [4:0] OP_SLT   = 5'd4;
  localparam logic [4:0] OP_SLTU  = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd8;
  localparam logic [4:0] OP_OR    = 5'd9;
  localparam logic [4:0] OP_AND   = 5'd10;
  localparam logic [4:0] OP_JAL   = 5'd11;
  localparam logic [4:0] OP_JALR  = 5'd12;
  localparam logic [4:0] OP_BEQ   = 5'd13;
  localparam logic [4:0] OP_BNE   = 5'd14;
  localparam logic [4:0] OP_BLT   = 5'd15;
  localparam logic [4:0] OP_BGE   = 5'd16;
  localparam logic [4:0] OP_BLTU  = 5'd17;
  localparam logic [4:0] OP_BGEU  = 5'd18;
  localparam logic [4:0] OP_MUL   = 5'd19;
  localparam logic [4:0] OP_MULHU = 5'd20;

  // Control FSM states of alu_mc
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } alu_mc_state_t;

  // Operation carried out by the iterative datapath
  typedef enum logic [2:0] {
    ITER_SLL   = 3'd0,
    ITER_SRL   = 3'd1,
    ITER_SRA   = 3'd2,
    ITER_MUL   = 3'd3,
    ITER_MULHU = 3'd4
  } iter_op_t;

endpackage

`default_nettype wire

// File: rtl/alu_iter_unit.sv
// ============================================================================
//  Module      : alu_iter_unit
//  Description : Iterative datapath for alu_mc. Shifts SHIFT_STEP bits per
//                cycle; with ALU_MC_MUL_EN defined it also performs an
//                unsigned shift-add multiply over WIDTH cycles.
//                'result_next' is the value the accumulator takes on the
//                coming edge; 'last' flags that this edge finishes the op.
//  Macro       : ALU_MC_MUL_EN (enables the multiplier datapath)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = $clog2(WIDTH),
  parameter int SHIFT_STEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  iter_op_t           op,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result_next,
  output logic               last
);

  // One extra bit so the counter can hold WIDTH for a multiply
  localparam int             CNT_W  = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);

  iter_op_t          op_q, op_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  step_amt;
  logic [WIDTH-1:0]  shift_next;
  logic              run_mul;
  logic              start_mul;

  // Final shift chunk may be shorter than SHIFT_STEP
  assign step_amt = (cnt_q > STEP_C) ? STEP_C : cnt_q;

`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     partial;

  assign run_mul   = (op_q == ITER_MUL) || (op_q == ITER_MULHU);
  assign start_mul = (op == ITER_MUL) || (op == ITER_MULHU);

  // Classic shift-add: add multiplicand into the high half when the LSB
  // of the remaining multiplier is set, then shift the pair right by one.
  assign partial   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {partial, prod_q[WIDTH-1:1]};
`else
  logic unused_operand_b;
  assign unused_operand_b = ^operand_b;
  assign run_mul   = 1'b0;
  assign start_mul = 1'b0;
`endif

  // One shift chunk of the current accumulator
  always_comb begin
    case (op_q)
      ITER_SLL: shift_next = acc_q << step_amt;
      ITER_SRL: shift_next = acc_q >> step_amt;
      default:  shift_next = $signed(acc_q) >>> step_amt;
    endcase
  end

  // Result presented to the controller for the edge that completes the op
  always_comb begin
    result_next = shift_next;
`ifdef ALU_MC_MUL_EN
    if (run_mul) begin
      result_next = (op_q == ITER_MULHU) ? prod_step[2*WIDTH-1:WIDTH]
                                         : prod_step[WIDTH-1:0];
    end
`endif
    if (run_mul) last = (cnt_q == CNT_W'(1));
    else         last = (cnt_q != '0) && (cnt_q <= STEP_C);
  end

  // Load on start, iterate while the counter is non-zero, clear on abort
  always_comb begin
    op_d  = op_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      op_d  = op;
      acc_d = operand_a;
      cnt_d = start_mul ? CNT_W'(WIDTH) : {1'b0, shamt};
    end else if (cnt_q != '0) begin
      if (run_mul) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        acc_d = shift_next;
        cnt_d = cnt_q - step_amt;
      end
    end
  end

  // Shifter / counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= ITER_SLL;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef ALU_MC_MUL_EN
  // Multiplicand and 2*WIDTH product accumulator updates
  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (!abort) begin
      if (start) begin
        mcand_d = operand_a;
        prod_d  = {{WIDTH{1'b0}}, operand_b};
      end else if (run_mul && (cnt_q != '0)) begin
        prod_d  = prod_step;
      end
    end
  end

  // Multiplier registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
//  Module      : alu_mc
//  Description : Multi-cycle RV32I execute-stage ALU with valid/ready input
//                and output handshakes. Single-cycle ops complete on the
//                accept edge; shifts (and optional multiply) iterate in
//                alu_iter_unit. Result and branch decision are registered.
//  Macro       : ALU_MC_MUL_EN (enables MUL / MULHU)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SHAMT_W     = $clog2(WIDTH),
  parameter int SHIFT_STEP  = 4,
  parameter int LINK_OFFSET = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               FLUSH,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [4:0]         ALU_INSTRUCTION,
  input  logic [WIDTH-1:0]   ALU_IN1,
  input  logic [WIDTH-1:0]   ALU_IN2,
  input  logic [SHAMT_W-1:0] SHIFT_AMOUNT,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [WIDTH-1:0]   ALU_OUT,
  output logic               BRANCH_TAKEN
);

  alu_mc_state_t    state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             taken_q, taken_d;

  logic             accept;
  logic             is_shift;
  logic             is_mul;
  logic [WIDTH-1:0] sc_result;
  logic             sc_taken;
  iter_op_t         iter_op;
  logic             iter_start;
  logic             iter_abort;
  logic [WIDTH-1:0] iter_result;
  logic             iter_last;

  // OUT_READY -> IN_READY is the only combinational input-to-output path
  assign IN_READY     = !FLUSH && ((state_q == IDLE) || ((state_q == DONE) && OUT_READY));
  assign accept       = IN_VALID && IN_READY;
  assign OUT_VALID    = (state_q == DONE);
  assign ALU_OUT      = alu_out_q;
  assign BRANCH_TAKEN = taken_q;

  assign is_shift = (ALU_INSTRUCTION == OP_SLL) || (ALU_INSTRUCTION == OP_SRL) ||
                    (ALU_INSTRUCTION == OP_SRA);
`ifdef ALU_MC_MUL_EN
  assign is_mul   = (ALU_INSTRUCTION == OP_MUL) || (ALU_INSTRUCTION == OP_MULHU);
`else
  assign is_mul   = 1'b0;
`endif

  // Single-cycle result and branch decision from the presented operands
  always_comb begin
    sc_result = '0;
    sc_taken  = 1'b0;
    case (ALU_INSTRUCTION)
      OP_ADD:  sc_result = ALU_IN1 + ALU_IN2;
      OP_SUB:  sc_result = ALU_IN1 - ALU_IN2;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(ALU_IN1) < $signed(ALU_IN2))};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (ALU_IN1 < ALU_IN2)};
      OP_XOR:  sc_result = ALU_IN1 ^ ALU_IN2;
      OP_OR:   sc_result = ALU_IN1 | ALU_IN2;
      OP_AND:  sc_result = ALU_IN1 & ALU_IN2;
      // A zero-distance shift is just a pass-through of operand 1
      OP_SLL, OP_SRL, OP_SRA: sc_result = ALU_IN1;
      OP_JAL, OP_JALR: begin
        sc_result = ALU_IN1 + WIDTH'(LINK_OFFSET);
        sc_taken  = 1'b1;
      end
      OP_BEQ:  sc_taken = (ALU_IN1 == ALU_IN2);
      OP_BNE:  sc_taken = (ALU_IN1 != ALU_IN2);
      OP_BLT:  sc_taken = ($signed(ALU_IN1) <  $signed(ALU_IN2));
      OP_BGE:  sc_taken = ($signed(ALU_IN1) >= $signed(ALU_IN2));
      OP_BLTU: sc_taken = (ALU_IN1 <  ALU_IN2);
      OP_BGEU: sc_taken = (ALU_IN1 >= ALU_IN2);
      default: ;
    endcase
  end

  // Map the opcode onto the iterative unit's operation
  always_comb begin
    iter_op = ITER_SLL;
    case (ALU_INSTRUCTION)
      OP_SRL:   iter_op = ITER_SRL;
      OP_SRA:   iter_op = ITER_SRA;
`ifdef ALU_MC_MUL_EN
      OP_MUL:   iter_op = ITER_MUL;
      OP_MULHU: iter_op = ITER_MULHU;
`endif
      default:  ;
    endcase
  end

  // Next-state, result capture and iterative-unit control
  always_comb begin
    state_d    = state_q;
    alu_out_d  = alu_out_q;
    taken_d    = taken_q;
    iter_start = 1'b0;
    iter_abort = 1'b0;
    if (FLUSH) begin
      state_d    = IDLE;
      iter_abort = 1'b1;
    end else if (accept) begin
      if (is_shift && (SHIFT_AMOUNT != '0)) begin
        state_d    = SHIFT;
        iter_start = 1'b1;
      end else if (is_mul) begin
        state_d    = MUL;
        iter_start = 1'b1;
      end else begin
        state_d   = DONE;
        alu_out_d = sc_result;
        taken_d   = sc_taken;
      end
    end else begin
      case (state_q)
        SHIFT: begin
          if (iter_last) begin
            state_d   = DONE;
            alu_out_d = iter_result;
            taken_d   = 1'b0;
          end
        end
`ifdef ALU_MC_MUL_EN
        MUL: begin
          if (iter_last) begin
            state_d   = DONE;
            alu_out_d = iter_result;
            taken_d   = 1'b0;
          end
        end
`endif
        DONE: begin
          if (OUT_READY) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs; reset clears them immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      alu_out_q <= '0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      taken_q   <= taken_d;
    end
  end

  alu_iter_unit #(
    .WIDTH      (WIDTH),
    .SHAMT_W    (SHAMT_W),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_iter (
    .clk         (CLK),
    .rst_n       (RST_N),
    .start       (iter_start),
    .abort       (iter_abort),
    .op          (iter_op),
    .operand_a   (ALU_IN1),
    .operand_b   (ALU_IN2),
    .shamt       (SHIFT_AMOUNT),
    .result_next (iter_result),
    .last        (iter_last)
  );

endmodule

`default_nettype wire

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the combinational execute-stage ALU.
- Accepts one RV32I integer/branch operation per valid/ready handshake and returns a registered result plus branch decision.
- Shifts are iterative, a configurable number of bits per cycle; optional iterative unsigned multiply.
- Sits between decode/issue and the EX/MEM pipeline register. Stalls upstream via IN_READY and tolerates back-pressure via OUT_READY.

Parameters:
- WIDTH, 32: operand/result width; power of two, ≥8.
- SHAMT_W, $clog2(WIDTH): shift-amount width.
- SHIFT_STEP, 4: bits shifted per cycle in SHIFT state; power of two, 1..WIDTH.
- LINK_OFFSET, 4: constant added to ALU_IN1 for JAL/JALR link value.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous abort of in-flight/pending op.
- IN_VALID  in  1  operation request valid.
- IN_READY  out  1  block can accept operation.
- ALU_INSTRUCTION  in  5  opcode (alu_pkg encoding).
- ALU_IN1  in  WIDTH  operand 1 (PC for JAL/JALR).
- ALU_IN2  in  WIDTH  operand 2.
- SHIFT_AMOUNT  in  SHAMT_W  shift amount for SLL/SRL/SRA.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- ALU_OUT  out  WIDTH  result.
- BRANCH_TAKEN  out  1  branch/jump taken.

Behaviour:
- Clock and reset are decided: one clock, CLK; reset RST_N is asynchronous, active-low.
- Reset: state=IDLE; OUT_VALID=0, ALU_OUT=0, BRANCH_TAKEN=0; internal counters cleared. Assertion mid-operation discards the op immediately.
- States are IDLE, SHIFT, MUL, DONE.
- IN_READY = (state==IDLE) || (state==DONE && OUT_READY); forced 0 while FLUSH=1.
- Accept occurs when IN_VALID && IN_READY. Operands and opcode are captured on that edge.
- Single-cycle ops: NOP, ADD, SUB, SLT, SLTU, XOR, OR, AND, JAL, JALR, BEQ..BGEU, and unknown opcodes.
  - Result is registered on the accept edge; next state is DONE.
  - Latency is 1 cycle; throughput is 1 op/cycle if OUT_READY is held high.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is signed; SLTU is unsigned; both give 0/1 zero-extended.
  - JAL/JALR: ALU_OUT = ALU_IN1+LINK_OFFSET (wrapping), BRANCH_TAKEN=1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: ALU_OUT=0, BRANCH_TAKEN = comparison (BLT/BGE signed).
  - All non-branch/non-jump ops: BRANCH_TAKEN=0.
  - NOP and unknown opcodes: ALU_OUT=0, BRANCH_TAKEN=0, normal 1-cycle latency, no error.
- Shifts (SLL/SRL/SRA):
  - SHIFT_AMOUNT==0: result = ALU_IN1, direct to DONE with 1-cycle latency.
  - Otherwise enter SHIFT. Each cycle shift by min(SHIFT_STEP, remaining); SRA fills with the sign bit.
  - Enter DONE when remaining reaches 0. Latency = 1 + ceil(shamt/SHIFT_STEP) cycles.
- DONE: OUT_VALID=1. ALU_OUT/BRANCH_TAKEN are held stable until OUT_READY.
  - On OUT_READY with no new accept: IDLE, OUT_VALID drops next cycle.
  - Simultaneous output handshake and new accept: the new op is loaded; OUT_VALID stays high for a single-cycle op.
- FLUSH (any state): next state IDLE, OUT_VALID=0 next cycle. An op presented the same cycle is not accepted. FLUSH has priority over OUT_READY and IN_VALID.
- No combinational path from IN_VALID or operands to outputs.
- OUT_READY→IN_READY is the only combinational path.

Optional Feature:
- Macro ALU_MC_MUL_EN.
- Defined: opcodes MUL and MULHU enabled.
  - Unsigned shift-add over WIDTH cycles in state MUL.
  - MUL returns the low WIDTH bits; MULHU returns the high WIDTH bits.
  - Latency WIDTH+1; BRANCH_TAKEN=0.
- Undefined: MUL/MULHU are treated as unknown opcodes (ALU_OUT=0, latency 1). No MUL state or 2*WIDTH accumulator is synthesised.

Decomposition:
- Shared package alu_pkg holds:
  - 5-bit opcode constants, each value unique: NOP=0, ADD=1, SUB=2, SLL=3, SLT=4, SLTU=5, XOR=6, SRL=7, SRA=8, OR=9, AND=10, JAL=11, JALR=12, BEQ=13, BNE=14, BLT=15, BGE=16, BLTU=17, BGEU=18, MUL=19, MULHU=20.
  - State enum alu_mc_state_t.
- One sub-module, alu_iter_unit: the iterative shifter plus optional multiplier datapath, with start/done, counter and accumulator. Control FSM, single-cycle ops and the handshake stay in alu_mc.

Test Plan:
- ADD 0xFFFFFFFF+0x00000002, OUT_READY=1 → OUT_VALID one cycle after accept, ALU_OUT=0x00000001, BRANCH_TAKEN=0.
- SRA 0x80000000 by 9, SHIFT_STEP=4 → 0xFFC00000, OUT_VALID 4 cycles after accept; IN_READY=0 during SHIFT.
- BLT 0xFFFFFFFE vs 0x00000001 → BRANCH_TAKEN=1; BLTU with the same operands → 0; JAL IN1=0x100 → ALU_OUT=0x104, BRANCH_TAKEN=1.
- Back-pressure: XOR result with OUT_READY=0 for 5 cycles → ALU_OUT stable, IN_READY=0. Then OUT_READY=1 with a queued SUB → SUB accepted the same cycle, OUT_VALID continuous.
- FLUSH during SHIFT (SLL by 31) plus RST_N pulse mid-DONE → IDLE, OUT_VALID=0 next cycle. Reset clears outputs asynchronously, before the next edge.
- With ALU_MC_MUL_EN: MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE after 33 cycles. Without the macro: same opcode → ALU_OUT=0 after 1 cycle.
